multicore_test_controller: RTL and testbench



---
 rtl/multicore_test_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicore_test_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_test_controller.sv
// Bring-up controller for NUM_CORES cores: lock sync, staggered reset release, done collection, PASS/FAIL.
// Optional macro RUN_CYCLE_COUNT_EN adds the o_run_cycles counter output.
module multicore_test_controller #(
  parameter int NUM_CORES       = 4,
  parameter int RST_PIPE_DEPTH  = 6,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_locked,
  input  logic [NUM_CORES-1:0] i_core_done,
  output logic [NUM_CORES-1:0] o_core_reset,
  output logic                 o_all_done,
  output logic                 o_timeout,
  output logic                 o_done_led,
  output logic [2:0]           o_state
`ifdef RUN_CYCLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] o_run_cycles
`endif
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_PASS      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST = CNT_WIDTH'((NUM_CORES - 1) * STAGGER_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                                   r_state;
  state_t                                   w_state_nxt;
  logic                                     r_lock_meta;
  logic                                     r_lock_sync;
  logic [CNT_WIDTH-1:0]                     r_hold_cnt;
  logic [CNT_WIDTH-1:0]                     r_stag_cnt;
  logic [CNT_WIDTH-1:0]                     r_run_cnt;
  logic [NUM_CORES-1:0]                     r_done_q;
  logic [NUM_CORES-1:0]                     w_done_nxt;
  logic [NUM_CORES-1:0]                     w_rel;
  logic [NUM_CORES-1:0][RST_PIPE_DEPTH-1:0] r_pipe;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign o_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Done bits that will be set after this edge; lets a same-cycle last done beat the timeout.
  always_comb begin
    w_done_nxt = r_done_q;
    if (r_state == S_RUN) begin
      w_done_nxt = r_done_q | (i_core_done & ~o_core_reset);
    end else begin
      w_done_nxt = r_done_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_LOCK: begin
        if (r_lock_sync) w_state_nxt = S_HOLD;
        else             w_state_nxt = S_WAIT_LOCK;
      end
      S_HOLD: begin
        if (!r_lock_sync)                w_state_nxt = S_WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RELEASE;
        else                             w_state_nxt = S_HOLD;
      end
      S_RELEASE: begin
        if (!r_lock_sync)                w_state_nxt = S_WAIT_LOCK;
        else if (r_stag_cnt == STAG_LAST) w_state_nxt = S_RUN;
        else                             w_state_nxt = S_RELEASE;
      end
      S_RUN: begin
        if (!r_lock_sync)              w_state_nxt = S_WAIT_LOCK;
        else if (&w_done_nxt)          w_state_nxt = S_PASS;
        else if (r_run_cnt == RUN_LAST) w_state_nxt = S_FAIL;
        else                           w_state_nxt = S_RUN;
      end
      S_PASS:  w_state_nxt = S_PASS;
      S_FAIL:  w_state_nxt = S_FAIL;
      default: w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_WAIT_LOCK;
      r_hold_cnt <= '0;
      r_stag_cnt <= '0;
      r_run_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= (r_state == S_HOLD && w_state_nxt == S_HOLD) ? sat_inc(r_hold_cnt) : '0;
      r_stag_cnt <= (r_state == S_RELEASE && w_state_nxt == S_RELEASE) ? sat_inc(r_stag_cnt) : '0;
      if (r_state == S_RUN && w_state_nxt == S_RUN) begin
        r_run_cnt <= (r_run_cnt == RUN_LAST) ? r_run_cnt : r_run_cnt + CNT_ONE;
      end else begin
        r_run_cnt <= '0;
      end
    end
  end

  // Core k is released once k*STAGGER_CYCLES cycles of RELEASE have elapsed, and stays released afterwards.
  always_comb begin
    w_rel = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      case (r_state)
        S_RELEASE:            w_rel[k] = (r_stag_cnt >= CNT_WIDTH'(k * STAGGER_CYCLES));
        S_RUN, S_PASS, S_FAIL: w_rel[k] = 1'b1;
        default:              w_rel[k] = 1'b0;
      endcase
    end
  end

  // Deassertion ripples through the pipe; assertion refills every stage at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '1;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (w_rel[k]) r_pipe[k] <= r_pipe[k] << 1;
        else          r_pipe[k] <= '1;
      end
    end
  end

  always_comb begin
    o_core_reset = '1;
    for (int k = 0; k < NUM_CORES; k++) begin
      o_core_reset[k] = r_pipe[k][RST_PIPE_DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_q   <= '0;
      o_all_done <= 1'b0;
      o_done_led <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (r_state == S_WAIT_LOCK || r_state == S_HOLD) r_done_q <= '0;
      else                                            r_done_q <= w_done_nxt;
      o_all_done <= &r_done_q;
      o_done_led <= (r_state == S_PASS);
      o_timeout  <= (r_state == S_FAIL);
    end
  end

`ifdef RUN_CYCLE_COUNT_EN
  // Counts RUN cycles, freezing on the edge that leaves RUN for a terminal state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_run_cycles <= '0;
    end else if (r_state == S_RUN && w_state_nxt == S_RUN) begin
      o_run_cycles <= sat_inc(o_run_cycles);
    end else if (r_state == S_WAIT_LOCK || r_state == S_HOLD) begin
      o_run_cycles <= '0;
    end else begin
      o_run_cycles <= o_run_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_multicore_test_controller.sv
// Scoreboard bench: a timeline model predicts every output change; a monitor pops and compares on each DUT change.
module tb_multicore_test_controller;
  localparam int NC  = 4;
  localparam int PD  = 6;
  localparam int HC  = 16;
  localparam int SC  = 2;
  localparam int TO  = 1000;
  localparam int CW  = 32;
  localparam int INF = 1 << 28;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_locked = 1'b0;
  logic [NC-1:0] i_core_done = '0;
  logic [NC-1:0] o_core_reset;
  logic          o_all_done, o_timeout, o_done_led;
  logic [2:0]    o_state;
`ifdef RUN_CYCLE_COUNT_EN
  logic [CW-1:0] o_run_cycles;
`endif

  multicore_test_controller #(
    .NUM_CORES(NC), .RST_PIPE_DEPTH(PD), .RST_HOLD_CYCLES(HC),
    .STAGGER_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .i_locked(i_locked), .i_core_done(i_core_done),
    .o_core_reset(o_core_reset), .o_all_done(o_all_done), .o_timeout(o_timeout),
    .o_done_led(o_done_led), .o_state(o_state)
`ifdef RUN_CYCLE_COUNT_EN
    , .o_run_cycles(o_run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  logic [31:0] prev [5];

  // scenario inputs (absolute cycles) and derived timeline
  int s_L, s_X;
  int s_d [NC];
  int t_th, t_tr, t_tu, t_w, t_p, t_f;
  int t_fk [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] sample(input int s);
    case (s)
      0:       return 32'(o_state);
      1:       return 32'(o_core_reset);
      2:       return {31'd0, o_all_done};
      3:       return {31'd0, o_timeout};
      4:       return {31'd0, o_done_led};
      default: return 32'd0;
    endcase
  endfunction

  // Timeline from lock time: sync (2) + FSM edge (1), hold, stagger, reset pipe.
  task automatic plan_times();
    t_th = s_L + 3;
    t_tr = t_th + HC;
    t_tu = t_tr + (NC - 1) * SC + 1;
    for (int k = 0; k < NC; k++) t_fk[k] = t_tr + k * SC + PD;
    t_w = (s_X < 0) ? INF : s_X + 3;
  endtask

  // A done bit latches one edge after input high, RUN, and core out of reset all hold.
  task automatic plan_done();
    int e;
    t_p = 0;
    for (int k = 0; k < NC; k++) begin
      e   = imax(imax(s_d[k], t_tu), t_fk[k]) + 1;
      t_p = imax(t_p, e);
    end
    t_f = t_tu + TO;
  endtask

  function automatic int state_at(input int t);
    if (t >= t_w) return 0;
    if (t_p <= t_f && t >= t_p) return 4;
    if (t_f < t_p && t >= t_f) return 5;
    if (t >= t_tu) return 3;
    if (t >= t_tr) return 2;
    if (t >= t_th) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model(input int s, input int t);
    logic [31:0] v;
    int          t_r;
    v   = 32'd0;
    t_r = (s_X < 0) ? INF : t_w + 1;
    case (s)
      0: v = 32'(state_at(t));
      1: for (int k = 0; k < NC; k++) v[k] = !(t >= t_fk[k] && t < t_r);
      2: v = (t_p <= t_f && t > t_p) ? 32'd1 : 32'd0;
      3: v = (t_f < t_p && t > t_f) ? 32'd1 : 32'd0;
      4: v = (t_p <= t_f && t > t_p) ? 32'd1 : 32'd0;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Monitor: every change of an observed output must match the next predicted event.
  always @(negedge clk) begin
    for (int s = 0; s < 5; s++) begin
      logic [31:0] cur;
      ev_t         e;
      cur = sample(s);
      if (mon_en && cur !== prev[s]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: sig %0d became %0h at cycle %0d, required no change", s, cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && e.sig == s && e.val === cur) n_pass++;
          else $display("FAIL event: got sig %0d=%0h at cycle %0d, required sig %0d=%0h at cycle %0d",
                        s, cur, cyc, e.sig, e.val, e.cyc);
        end
      end
      prev[s] = cur;
    end
  end

  task automatic scenario(input bit ll);
    int  end_t;
    ev_t e;
    plan_done();
    end_t = ll ? t_w + 6 : imin(t_p, t_f) + 6;
    for (int t = cyc + 1; t <= end_t; t++) begin
      for (int s = 0; s < 5; s++) begin
        if (model(s, t) !== model(s, t - 1)) begin
          e.cyc = t; e.sig = s; e.val = model(s, t);
          exp_q.push_back(e);
        end
      end
    end
    while (cyc < end_t) begin
      @(posedge clk); #1;
      i_locked = (cyc >= s_L) && (s_X < 0 || cyc < s_X);
      for (int k = 0; k < NC; k++) i_core_done[k] = (cyc >= s_d[k]);
    end
    @(negedge clk); #1;
    check("events_drained", 32'(exp_q.size()), 32'd0);
`ifdef RUN_CYCLE_COUNT_EN
    if (!ll) check("run_cycles", o_run_cycles, 32'(imin(t_p, t_f) - 1 - t_tu));
`endif
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    mon_en      = 1'b0;
    reset       = 1'b1;
    i_locked    = 1'b0;
    i_core_done = '0;
    #1;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_core_reset", 32'(o_core_reset), 32'((1 << NC) - 1));
    check("rst_all_done", {31'd0, o_all_done}, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    check("rst_done_led", {31'd0, o_done_led}, 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic new_lock(input int off);
    s_L = cyc + off;
    s_X = -1;
    for (int k = 0; k < NC; k++) s_d[k] = INF;
    plan_times();
  endtask

  task automatic rand_dones(input int miss);
    for (int k = 0; k < NC; k++)
      s_d[k] = (k == miss) ? INF : t_tu - 10 + int'($urandom_range(0, 200));
  endtask

  task automatic lockloss_then_relock();
    int w;
    new_lock(1 + int'($urandom_range(0, 5)));
    w   = t_tr + 1 + int'($urandom % 32'(t_tu - t_tr));
    s_X = w - 3;
    plan_times();
    scenario(1'b1);
    new_lock(2 + int'($urandom_range(0, 5)));
    rand_dones(-1);
    scenario(1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // lock at cycle 10 after reset release; dones for cores 3,1,0,2 at 20-cycle spacing
    new_lock(10);
    s_d[3] = t_fk[NC-1] + 5;
    s_d[1] = s_d[3] + 20;
    s_d[0] = s_d[3] + 40;
    s_d[2] = s_d[3] + 60;
    scenario(1'b0);
    do_reset();

    // core 3 never reports: timeout
    new_lock(1 + int'($urandom_range(0, 5)));
    rand_dones(3);
    scenario(1'b0);
    do_reset();

    // lock lost in RELEASE after core 0 released, then full relock sequence
    lockloss_then_relock();
    do_reset();

    // core 3 done held high from before release
    new_lock(3);
    rand_dones(-1);
    s_d[3] = cyc;
    scenario(1'b0);
    do_reset();

    // last done latches on the timeout edge: PASS wins
    new_lock(2);
    rand_dones(-1);
    s_d[3] = t_tu + TO - 1;
    scenario(1'b0);
    do_reset();

    // last done one cycle too late: FAIL
    new_lock(2);
    rand_dones(-1);
    s_d[3] = t_tu + TO;
    scenario(1'b0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: begin new_lock(1 + int'($urandom_range(0, 8))); rand_dones(-1); scenario(1'b0); end
        1: begin new_lock(1 + int'($urandom_range(0, 8))); rand_dones(int'($urandom_range(0, NC - 1))); scenario(1'b0); end
        default: lockloss_then_relock();
      endcase
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
